iter_alu: RTL and testbench

- Parametrised-width execute-stage ALU. Keeps the single-cycle ops (add/sub/logic/shift/compare) and adds iterative multiply and divide, with signed and unsigned variants of each.
- Operands and results are registered behind a valid/ready handshake, so the unit stalls the pipeline for multi-cycle ops.
- Sits in the EX stage in place of the combinational ALU. The hazard unit stalls on in_ready=0 and can kill an in-flight op with flush.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/addr_nbit.sv | 14 +
 rtl/iter_alu.sv | 181 ++++++++++++++++++
 tb/tb_iter_alu.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU opcodes and iterative-ALU sequencing states.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, MUL, MULU, DIV, DIVU
    } aluop_t;

    typedef enum logic [1:0] {IDLE, MULT, DIVD, DONE} ialu_state_t;

    // Ops whose flags come from the shared adder.
    function automatic logic is_arith(input aluop_t op);
        return (op == ADD) || (op == SUB) || (op == SLT) || (op == SLTU);
    endfunction

endpackage

// File: rtl/addr_nbit.sv
// N-bit ripple adder with carry-in, carry-out and signed overflow.
module addr_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/iter_alu.sv
// EX-stage ALU: single-cycle ops plus iterative shift-add multiply and restoring
// divide, all behind a valid/ready handshake with registered results.
module iter_alu
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  aluop_t           op,
    input  logic [WIDTH-1:0] oprnd1,
    input  logic [WIDTH-1:0] oprnd2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alurst,
    output logic [WIDTH-1:0] alurst_hi,
    output logic             vldflg,
    output logic             cryflg,
    output logic             ngtflg,
    output logic             zroflg,
    output logic             divzro
);
    ialu_state_t      state;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [SHW-1:0]   cnt;
    logic             neg_lo, neg_hi;

    logic [WIDTH-1:0] add_b, add_sum, res;
    logic             add_cin, add_cout, add_ovf;
    logic [3:0]       flg;
    logic             sgn_op, s1, s2, accept, last;
    logic [WIDTH-1:0] mag1, mag2;
    logic [SHW-1:0]   shamt;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign last     = (cnt == SHW'(WIDTH-1));
    assign shamt    = oprnd2[SHW-1:0];

    // Subtract (SUB/SLT/SLTU) is A + ~B + 1, so cout=1 means no borrow.
    assign add_b   = (op == ADD) ? oprnd2 : ~oprnd2;
    assign add_cin = (op != ADD);

    addr_nbit #(.WIDTH(WIDTH)) u_add (
        .a(oprnd1), .b(add_b), .cin(add_cin),
        .sum(add_sum), .cout(add_cout), .ovf(add_ovf)
    );

    always_comb begin
        res = oprnd1;
        case (op)
            ADD, SUB: res = add_sum;
            AND:      res = oprnd1 & oprnd2;
            OR:       res = oprnd1 | oprnd2;
            XOR:      res = oprnd1 ^ oprnd2;
            NOR:      res = ~(oprnd1 | oprnd2);
            SLL:      res = oprnd1 << shamt;
            SRL:      res = oprnd1 >> shamt;
            SRA:      res = $signed(oprnd1) >>> shamt;
            SLT:      res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
            SLTU:     res = {{(WIDTH-1){1'b0}}, ~add_cout};
            default:  res = oprnd1;
        endcase
        flg = is_arith(op) ? {add_ovf, add_cout, add_sum[WIDTH-1], add_sum == '0} : 4'b0;
    end

    assign sgn_op = (op == MUL) || (op == DIV);
    assign s1     = sgn_op && oprnd1[WIDTH-1];
    assign s2     = sgn_op && oprnd2[WIDTH-1];
    assign mag1   = s1 ? -oprnd1 : oprnd1;
    assign mag2   = s2 ? -oprnd2 : oprnd2;

    // Multiply: {acc_hi,acc_lo} is the product register, multiplier in acc_lo.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mprod, mfinal;
    assign msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mprod  = {msum, acc_lo[WIDTH-1:1]};
    assign mfinal = neg_lo ? -mprod : mprod;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   dshift, ddiff;
    logic             dge;
    logic [WIDTH-1:0] drem, dquo;
    assign dshift = {acc_hi, acc_lo[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, opb};
    assign dge    = dshift >= {1'b0, opb};
    assign drem   = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
    assign dquo   = {acc_lo[WIDTH-2:0], dge};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alurst    <= '0;
            alurst_hi <= '0;
            {vldflg, cryflg, ngtflg, zroflg} <= 4'b0;
            divzro    <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            cnt       <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MULT: begin
                    {acc_hi, acc_lo} <= mprod;
                    cnt <= cnt + SHW'(1);
                    if (last) begin
                        {alurst_hi, alurst} <= mfinal;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DIVD: begin
                    acc_hi <= drem;
                    acc_lo <= dquo;
                    cnt    <= cnt + SHW'(1);
                    if (last) begin
                        alurst    <= neg_lo ? -dquo : dquo;
                        alurst_hi <= neg_hi ? -drem : drem;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (accept) begin
                        cnt    <= '0;
                        divzro <= 1'b0;
                        {vldflg, cryflg, ngtflg, zroflg} <= flg;
                        case (op)
                            MUL, MULU: begin
                                acc_hi    <= '0;
                                acc_lo    <= mag1;
                                opb       <= mag2;
                                neg_lo    <= s1 ^ s2;
                                out_valid <= 1'b0;
                                state     <= MULT;
                            end
                            DIV, DIVU: begin
                                if (oprnd2 == '0) begin
                                    alurst    <= '1;
                                    alurst_hi <= oprnd1;
                                    divzro    <= 1'b1;
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    acc_hi    <= '0;
                                    acc_lo    <= mag1;
                                    opb       <= mag2;
                                    neg_lo    <= s1 ^ s2;
                                    neg_hi    <= s1;
                                    out_valid <= 1'b0;
                                    state     <= DIVD;
                                end
                            end
                            default: begin
                                alurst    <= res;
                                alurst_hi <= '0;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu at WIDTH=32 with hand-computed expectations.
module tb_iter_alu;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST, in_valid, in_ready, flush, out_valid, out_ready;
    aluop_t      op;
    logic [31:0] oprnd1, oprnd2, alurst, alurst_hi;
    logic        vldflg, cryflg, ngtflg, zroflg, divzro;

    int n_chk  = 0;
    int n_fail = 0;

    iter_alu #(.WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .oprnd1(oprnd1), .oprnd2(oprnd2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alurst(alurst), .alurst_hi(alurst_hi),
        .vldflg(vldflg), .cryflg(cryflg), .ngtflg(ngtflg), .zroflg(zroflg), .divzro(divzro)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input aluop_t o, input logic [31:0] a, input logic [31:0] b);
        op = o; oprnd1 = a; oprnd2 = b; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from accept (accept edge = 1) until out_valid; notes any in_ready while busy.
    task automatic wait_done(output int lat, output bit rdy_seen);
        lat = 1; rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic single(input string tag, input aluop_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
        issue(o, a, b);
        chk({tag, "_vld"}, out_valid, 1);
        chk(tag, alurst, er);
        chk({tag, "_hi"}, alurst_hi, 0);
        chk({tag, "_flg"}, {vldflg, cryflg, ngtflg, zroflg}, ef);
        @(posedge CLK); #1;
        chk({tag, "_ret"}, out_valid, 0);
    endtask

    task automatic multi(input string tag, input aluop_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] er, input int elat,
                         input logic edz);
        int lat; bit rdy;
        issue(o, a, b);
        wait_done(lat, rdy);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy_rdy"}, rdy, 0);
        chk(tag, {alurst_hi, alurst}, er);
        chk({tag, "_dz_flg"}, {divzro, vldflg, cryflg, ngtflg, zroflg}, {edz, 4'b0});
        @(posedge CLK); #1;
    endtask

    initial begin
        int  lat;
        bit  rdy, seen;
        nRST = 1'b0; in_valid = 1'b0; op = ADD; oprnd1 = '0; oprnd2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge CLK); #1;
        chk("rst_ctl", {in_ready, out_valid, vldflg, cryflg, ngtflg, zroflg, divzro}, 7'b1000000);
        chk("rst_res", {alurst_hi, alurst}, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        single("add_ovf", ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010);
        single("sub_zro", SUB,  32'h5,        32'h5,        32'h0,        4'b0101);
        single("slt",     SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        4'b0110);
        single("sltu",    SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110);
        single("slt_min", SLT,  32'h80000000, 32'h1,        32'h1,        4'b1100);
        single("sra",     SRA,  32'h80000000, 32'h24,       32'hF8000000, 4'b0000);
        single("sll31",   SLL,  32'h1,        32'h3F,       32'h80000000, 4'b0000);
        single("nor",     NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 4'b0000);
        single("undef",   aluop_t'(4'hF), 32'h12345678, 32'h1, 32'h12345678, 4'b0000);

        multi("mul_neg",  MUL,  32'hFFFFFFFD, 32'h7,        64'hFFFFFFFF_FFFFFFEB, 33, 1'b0);
        multi("mulu",     MULU, 32'hFFFFFFFF, 32'h2,        64'h00000001_FFFFFFFE, 33, 1'b0);
        multi("mul_min",  MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, 1'b0);
        multi("div_neg",  DIV,  32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        multi("div_min",  DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
        multi("divu",     DIVU, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 1'b0);
        multi("divu_z",   DIVU, 32'h5,        32'h0,        64'h00000005_FFFFFFFF, 1,  1'b1);

        // Result held under back-pressure, then retire and accept on the same edge.
        out_ready = 1'b0;
        issue(MUL, 32'd6, 32'd7);
        wait_done(lat, rdy);
        chk("hold_lat", lat, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("hold_stable", {in_ready, out_valid, alurst_hi, alurst}, {2'b01, 64'd42});
        end
        out_ready = 1'b1; op = ADD; oprnd1 = 32'd2; oprnd2 = 32'd3; in_valid = 1'b1;
        #1;
        chk("b2b_rdy", in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("b2b_res", {out_valid, alurst_hi, alurst}, {1'b1, 64'd5});
        @(posedge CLK); #1;
        chk("b2b_ret", out_valid, 0);

        // Flush mid-divide; the op offered in the flush cycle must be dropped.
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge CLK);
        #1;
        flush = 1'b1; op = ADD; oprnd1 = 32'd1; oprnd2 = 32'd1; in_valid = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {in_ready, out_valid}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            seen |= out_valid;
        end
        chk("flush_novld", seen, 0);

        // Asynchronous reset in the middle of a multiply.
        issue(MUL, 32'd3, 32'd4);
        repeat (5) @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_ctl", {in_ready, out_valid, vldflg, cryflg, ngtflg, zroflg, divzro}, 7'b1000000);
        chk("arst_res", {alurst_hi, alurst}, 0);
        #2;
        nRST = 1'b1;
        @(posedge CLK); #1;
        single("post_rst", ADD, 32'd2, 32'd2, 32'd4, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
